// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with a KMP transition table built from the
// parameters at elaboration, plus a saturating count of completed matches.
module moore_seq_detector #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            SW      = $clog2(N + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             enable,
    input  logic             clr,
    output logic             y_out,
    output logic [SW-1:0]    state_out,
    output logic [CNT_W-1:0] match_count
);

    localparam int NS = 1 << SW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Only S0 and SN are named; the state value is the matched-prefix length k.
    typedef enum logic [SW-1:0] {
        S0 = SW'(0),
        SN = SW'(N)
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Pattern bit p_i (1-based), p_1 being the first bit expected on x_in.
    function automatic logic pbit(input int i);
        logic [N-1:0] t;
        t = PATTERN >> (N - i);
        return t[0];
    endfunction

    // Next state from k on bit b: longest prefix of the pattern that is a
    // suffix of (p_1..p_k, b). States above N fall back to S0.
    function automatic logic [SW-1:0] next_of(input int k, input logic b);
        logic [SW-1:0] res;
        logic          found;
        logic          ok;
        logic          sbit;
        int            kk;
        int            idx;
        res   = '0;
        found = 1'b0;
        kk    = k;
        if (k == N && !OVERLAP) kk = 0;
        if (k <= N) begin
            for (int j = N; j >= 1; j--) begin
                if (!found && j <= kk + 1) begin
                    ok = 1'b1;
                    for (int m = 1; m <= N; m++) begin
                        if (m <= j) begin
                            idx = kk + 1 - j + m;
                            if (idx <= kk) sbit = pbit(idx);
                            else           sbit = b;
                            if (sbit != pbit(m)) ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        res   = SW'(j);
                        found = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    logic [SW-1:0] tab0 [NS];
    logic [SW-1:0] tab1 [NS];

    for (genvar s = 0; s < NS; s++) begin : g_tab
        assign tab0[s] = next_of(s, 1'b0);
        assign tab1[s] = next_of(s, 1'b1);
    end

    // enable qualifies x_in for one cycle; with enable low nothing advances.
    // clr wins over any transition, enabled or not.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = S0;
            cnt_nxt   = '0;
        end else if (enable) begin
            state_nxt = state_t'(x_in ? tab1[state] : tab0[state]);
            if (state_nxt == SN && cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign y_out       = (state == SN);
    assign state_out   = state;
    assign match_count = cnt;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: three configurations share one input stream and
// are scored against a history-based reference model, plus directed checks.
module tb_moore_seq_detector;

    logic clock = 1'b0;
    logic reset;
    logic x_in;
    logic enable;
    logic clr;

    logic       y_ov, y_no, y_sat;
    logic [2:0] st_ov, st_no;
    logic [1:0] st_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    moore_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clock(clock), .reset(reset), .x_in(x_in), .enable(enable), .clr(clr),
        .y_out(y_ov), .state_out(st_ov), .match_count(cnt_ov));

    moore_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clock(clock), .reset(reset), .x_in(x_in), .enable(enable), .clr(clr),
        .y_out(y_no), .state_out(st_no), .match_count(cnt_no));

    moore_seq_detector #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .x_in(x_in), .enable(enable), .clr(clr),
        .y_out(y_sat), .state_out(st_sat), .match_count(cnt_sat));

    // ---------------- reference model ----------------
    int          m_n   [3] = '{4, 4, 2};
    logic [7:0]  m_pat [3] = '{8'b1011, 8'b1011, 8'b11};
    bit          m_ov  [3] = '{1'b1, 1'b0, 1'b1};
    int          m_max [3] = '{255, 255, 3};
    logic [63:0] m_hist[3];
    int          m_len [3];
    int          m_k   [3];
    int          m_cnt [3];

    // Longest j <= N such that the last j consumed bits spell p_1..p_j.
    function automatic int model_state(int d);
        int  lim;
        bit  ok;
        lim = (m_len[d] < m_n[d]) ? m_len[d] : m_n[d];
        for (int j = lim; j >= 1; j--) begin
            ok = 1'b1;
            for (int m = 0; m < j; m++)
                if (m_hist[d][j-1-m] != m_pat[d][m_n[d]-1-m]) ok = 1'b0;
            if (ok) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_hist[d] = '0; m_len[d] = 0; m_k[d] = 0; m_cnt[d] = 0;
        end
    endtask

    task automatic model_step(int d, logic b, logic en, logic c);
        if (c) begin
            m_hist[d] = '0; m_len[d] = 0; m_k[d] = 0; m_cnt[d] = 0;
        end else if (en) begin
            m_hist[d] = {m_hist[d][62:0], b};
            if (m_len[d] < 32) m_len[d]++;
            m_k[d] = model_state(d);
            if (m_k[d] == m_n[d]) begin
                if (m_cnt[d] < m_max[d]) m_cnt[d]++;
                // a completed match is not reused as a prefix in non-overlap mode
                if (!m_ov[d]) m_len[d] = 0;
            end
        end
    endtask

    function automatic logic [15:0] exp_word(int d);
        logic [3:0] k;
        logic [7:0] c;
        k = m_k[d][3:0];
        c = m_cnt[d][7:0];
        return {3'b000, k, (m_k[d] == m_n[d]), c};
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[3][$];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_all();
        for (int d = 0; d < 3; d++) exp_q[d].push_back(exp_word(d));
    endtask

    task automatic compare_all();
        logic [15:0] obs [3];
        obs[0] = {3'b000, 1'b0, st_ov,  y_ov,  cnt_ov};
        obs[1] = {3'b000, 1'b0, st_no,  y_no,  cnt_no};
        obs[2] = {3'b000, 2'b00, st_sat, y_sat, 6'b0, cnt_sat};
        for (int d = 0; d < 3; d++) begin
            if (exp_q[d].size() == 0) check_eq($sformatf("sb_empty%0d", d), 16'h1, 16'h0);
            else check_eq($sformatf("sb_dut%0d", d), obs[d], exp_q[d].pop_front());
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic b, input logic en, input logic c);
        x_in = b; enable = en; clr = c;
        for (int d = 0; d < 3; d++) model_step(d, b, en, c);
        push_all();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        push_all();
        compare_all();
        #2;
        reset = 1'b1;
    endtask

    task automatic send(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] seq;
        logic [1:0]  sat_exp [6];
        logic [2:0]  fail_exp [6];
        reset = 1'b0; x_in = 1'b0; enable = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        push_all();
        compare_all();
        check_eq("reset_y", {15'b0, y_ov}, 16'h0);

        // registers hold while reset is low even with enabled edges
        x_in = 1'b1; enable = 1'b1;
        @(posedge clock); #1;
        check_eq("hold_in_reset", {13'b0, st_ov}, 16'h0);
        reset = 1'b1;

        // overlap / non-overlap
        seq = 16'b1011011;
        send(seq, 7);
        check_eq("ov_count", {8'b0, cnt_ov}, 16'd2);
        check_eq("ov_state", {13'b0, st_ov}, 16'd4);
        check_eq("no_count", {8'b0, cnt_no}, 16'd1);
        check_eq("no_state", {13'b0, st_no}, 16'd1);

        // failure transition
        async_reset();
        fail_exp = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4};
        seq = 16'b101011;
        for (int i = 5; i >= 0; i--) begin
            step(seq[i], 1'b1, 1'b0);
            check_eq($sformatf("fail_state%0d", 5 - i), {13'b0, st_ov}, {13'b0, fail_exp[5-i]});
        end
        check_eq("fail_detect", {15'b0, y_ov}, 16'h1);

        // enable stall
        async_reset();
        send(16'b10, 2);
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b0, 1'b0);
            check_eq("stall_hold", {13'b0, st_ov}, 16'd2);
        end
        send(16'b11, 2);
        check_eq("stall_detect", {15'b0, y_ov}, 16'h1);
        check_eq("stall_count", {8'b0, cnt_ov}, 16'd1);

        // saturation on the N=2 instance
        async_reset();
        check_eq("sat_init", {14'b0, cnt_sat}, 16'd0);
        sat_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check_eq($sformatf("sat_cnt%0d", i), {14'b0, cnt_sat}, {14'b0, sat_exp[i]});
        end

        // asynchronous reset while in S3
        async_reset();
        send(16'b101101, 6);
        check_eq("pre_rst_state", {13'b0, st_ov}, 16'd3);
        reset = 1'b0;
        #1;
        check_eq("async_state", {13'b0, st_ov}, 16'd0);
        check_eq("async_count", {8'b0, cnt_ov}, 16'd0);
        model_reset();
        #2;
        reset = 1'b1;

        // clear on the edge that would complete a match
        send(16'b101101, 6);
        step(1'b1, 1'b1, 1'b1);
        check_eq("clr_state", {13'b0, st_ov}, 16'd0);
        check_eq("clr_count", {8'b0, cnt_ov}, 16'd0);
        check_eq("clr_y", {15'b0, y_ov}, 16'h0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
MOORE_SEQ_DETECTOR -- requirements
Module: moore_seq_detector

Interface
REQ-001 Parameter N, default 4, pattern length in bits, legal range 2..8.
REQ-002 Parameter PATTERN, default 4'b1011, N-bit target sequence; PATTERN[N-1] is the first bit expected on the serial input.
REQ-003 Parameter OVERLAP, default 1, selects the mode: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8, width of the match counter.
REQ-005 Local width SW = $clog2(N+1), the state width.
REQ-006 clock  input  1  single clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 x_in  input  1  serial data bit, sampled on the rising clock edge.
REQ-009 enable  input  1  when 1, x_in is consumed this cycle; when 0, all registers hold.
REQ-010 clr  input  1  synchronous clear of state and counter.
REQ-011 y_out  output  1  Moore detect flag.
REQ-012 state_out  output  SW  current state index k, the number of pattern bits currently matched.
REQ-013 match_count  output  CNT_W  saturating count of completed matches.

Function
REQ-014 The state set is S0..SN, encoded as unsigned k in SW bits; encodings above N are unreachable.
- If one is forced, it returns to S0 on the next enabled edge.
REQ-015 Define p1..pN as the pattern bits, where p1 = PATTERN[N-1] and pN = PATTERN[0].
REQ-016 From Sk with k<N and enabled input b == p(k+1), the next state is S(k+1).
REQ-017 From Sk with k<N and b != p(k+1), the next state is Sj.
- j is the largest value in 0..k such that the last j bits of (p1..pk, b) equal p1..pj.
- This is the KMP failure transition.
REQ-018 From SN with OVERLAP=1, the next state follows REQ-017, applied to the string (p1..pN, b) with k=N.
REQ-019 From SN with OVERLAP=0, the next state is the transition that S0 would take on b.
REQ-020 The transition function shall be derived from the parameters at elaboration; no per-pattern hand coding.
REQ-021 y_out = 1 iff state == SN.
- It is a pure function of state only, with no combinational path from x_in.
REQ-022 Latency: y_out rises in the cycle immediately following the rising edge that sampled pN.
- It stays high for exactly one enabled cycle, unless the next transition re-enters SN.
REQ-023 match_count increments by 1 on every edge where the next state is SN and enable=1.
REQ-024 match_count saturates at 2^CNT_W-1 and does not wrap.
REQ-025 enable=0: state and match_count hold, x_in is ignored, and y_out keeps its value.
REQ-026 clr=1 on an edge: state becomes S0 and match_count becomes 0, regardless of enable and x_in.
- clr has priority over all transitions.
REQ-027 clr and enable are both sampled only on the rising clock edge.
REQ-028 state_out = state, registered directly.

Reset
REQ-029 reset=0 asynchronously forces state to S0, y_out to 0, state_out to 0 and match_count to 0, independent of clock.
REQ-030 While reset=0, all registers stay at their reset values.
- The first enabled edge after reset deasserts consumes x_in from S0.
REQ-031 Reset asserted mid-sequence discards the partial match; no detect is produced for that sequence.

Verification
REQ-032 Overlap test. Config N=4, PATTERN=1011, OVERLAP=1, enable=1.
- Stimulus: x_in = 1,0,1,1,0,1,1.
- Required: y_out high after the 4th and 7th edges only; match_count = 2; state_out after the 7th edge = 4.
REQ-033 Non-overlap test. Same config with OVERLAP=0, same stimulus.
- Required: y_out high after the 4th edge only; state_out after the 7th edge = 1; match_count = 1.
REQ-034 Failure-transition test. Config N=4, PATTERN=1011.
- Stimulus: x_in = 1,0,1,0,1,1.
- Required: state_out sequence 1,2,3,2,3,4; y_out high after the 6th edge.
REQ-035 Enable-stall test. Stimulus: 1,0 then enable=0 for 3 cycles with x_in toggling, then 1,1.
- Required: state_out holds at 2 during the stall; detect after the final edge; match_count = 1.
REQ-036 Saturation test. Config CNT_W=2, OVERLAP=1, PATTERN=11, N=2.
- Stimulus: six consecutive 1s.
- Required: match_count goes 0,0,1,2,3,3,3 and stays at 3.
REQ-037 Reset and clear test.
- Drop reset while in S3 with no clock edge: state_out = 0 and match_count = 0 immediately.
- Pulse clr=1 with x_in completing a match: state_out = 0, no count increment, y_out = 0 on the next cycle.
